// File: rtl/exe_div.sv
// Iterative restoring divider for the EXE stage: one quotient bit per cycle,
// signed/unsigned, divide-by-zero shortcut, flushable via annul_i.
module exe_div #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        annul_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(ITER + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = signed'(v);
    return unsigned'(-s);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic            is_signed);
    return (is_signed && v[DATA_W-1]) ? neg2c(v) : v;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              quot_neg_q, quot_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W:0]   part_q, part_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not go negative. The quotient
  // bits are shifted into the freed low end of the dividend register.
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;
  logic [DATA_W:0]   part_next;
  logic [DATA_W-1:0] dvd_next;

  always_comb begin
    shifted = {part_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    if (!diff[DATA_W+1]) begin
      part_next = diff[DATA_W:0];
      dvd_next  = {dvd_q[DATA_W-2:0], 1'b1};
    end else begin
      part_next = shifted;
      dvd_next  = {dvd_q[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    op1_d      = op1_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    part_d     = part_q;
    quot_d     = quot_q;
    rem_d      = rem_q;

    if (annul_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      quot_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d    = (op2_i == '0) ? BYZERO : ON;
            cnt_d      = '0;
            quot_neg_d = signed_i & (op1_i[DATA_W-1] ^ op2_i[DATA_W-1]);
            rem_neg_d  = signed_i & op1_i[DATA_W-1];
            op1_d      = op1_i;
            dvs_d      = magnitude(op2_i, signed_i);
            dvd_d      = magnitude(op1_i, signed_i);
            part_d     = '0;
          end
        end
        BYZERO: begin
          state_d = END;
          quot_d  = '1;
          rem_d   = op1_q;
        end
        ON: begin
          dvd_d  = dvd_next;
          part_d = part_next;
          if (cnt_q == LAST_CNT) begin
            state_d = END;
            cnt_d   = '0;
            quot_d  = quot_neg_q ? neg2c(dvd_next) : dvd_next;
            rem_d   = rem_neg_q ? neg2c(part_next[DATA_W-1:0]) : part_next[DATA_W-1:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (!start_i) begin
            state_d = IDLE;
            quot_d  = '0;
            rem_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      op1_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      part_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      op1_q      <= op1_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      part_q     <= part_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  // Results are only visible in END; stall drops in that same cycle so the
  // instruction advances exactly when ready_o rises.
  assign ready_o     = (state_q == END);
  assign quot_o      = ready_o ? quot_q : '0;
  assign rem_o       = ready_o ? rem_q : '0;
  assign stall_req_o = start_i & ~annul_i & ~rst_i & (state_q != END);

endmodule

// File: tb/tb_exe_div.sv
// Directed bench for exe_div: hand-computed quotient/remainder, latency,
// stall behaviour, annul and reset mid-operation.
module tb_exe_div;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        annul_i;
  logic [31:0] quot_o;
  logic [31:0] rem_o;
  logic        ready_o;
  logic        stall_req_o;

  int n_tests = 0;
  int n_fail  = 0;

  exe_div #(.ITER(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .annul_i     (annul_i),
    .quot_o      (quot_o),
    .rem_o       (rem_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Called just after a clock edge with the DUT in IDLE; the current cycle is t.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int lat);
    int k;
    logic busy_ok;
    logic [31:0] q_seen;
    logic [31:0] r_seen;
    signed_i = sg;
    op1_i    = a;
    op2_i    = b;
    start_i  = 1'b1;
    #1;
    chk({tag, " stall_t"}, {31'd0, stall_req_o}, 32'd1);
    k = 0;
    busy_ok = 1'b1;
    while (!ready_o && k < 60) begin
      next_cycle();
      k++;
      if (k == 1) begin
        signed_i = ~sg;
        op1_i    = ~a;
        op2_i    = ~b;
      end
      if (!ready_o && (!stall_req_o || quot_o != 0 || rem_o != 0)) busy_ok = 1'b0;
    end
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " latency"}, k, lat);
    chk({tag, " quot"}, quot_o, eq);
    chk({tag, " rem"}, rem_o, er);
    chk({tag, " stall_end"}, {31'd0, stall_req_o}, 32'd0);
    q_seen = quot_o;
    r_seen = rem_o;
    next_cycle();
    chk({tag, " hold_rdy"}, {31'd0, ready_o}, 32'd1);
    chk({tag, " hold_q"}, quot_o, q_seen);
    chk({tag, " hold_r"}, rem_o, r_seen);
    start_i = 1'b0;
    next_cycle();
    chk({tag, " idle_rdy"}, {31'd0, ready_o}, 32'd0);
    chk({tag, " idle_q"}, quot_o, 32'd0);
  endtask

  initial begin
    int k;
    logic rdy_seen;
    rst_i    = 1'b1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    op1_i    = 32'd100;
    op2_i    = 32'd7;
    annul_i  = 1'b0;
    repeat (3) next_cycle();
    chk("rst ready", {31'd0, ready_o}, 32'd0);
    chk("rst quot", quot_o, 32'd0);
    chk("rst rem", rem_o, 32'd0);
    chk("rst stall", {31'd0, stall_req_o}, 32'd0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    next_cycle();

    do_div("u100/7",   1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         33);
    do_div("s-100/7",  1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE,  33);
    do_div("s100/-7",  1'b1, 32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2,  32'd2,         33);
    do_div("s-100/-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE,  33);
    do_div("uFFFF/3",  1'b0, 32'hFFFFFFFF,  32'd3,        32'h55555555,  32'd0,         33);
    do_div("s-1/3",    1'b1, 32'hFFFFFFFF,  32'd3,        32'd0,         32'hFFFFFFFF,  33);
    do_div("u7/100",   1'b0, 32'd7,         32'd100,      32'd0,         32'd7,         33);
    do_div("udiv0",    1'b0, 32'h1234,      32'd0,        32'hFFFFFFFF,  32'h1234,      2);
    do_div("sdiv0",    1'b1, 32'h1234,      32'd0,        32'hFFFFFFFF,  32'h1234,      2);
    do_div("sdiv0neg", 1'b1, 32'hFFFFFF9C,  32'd0,        32'hFFFFFFFF,  32'hFFFFFF9C,  2);
    do_div("ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  32'd0,         33);

    // Annul in the middle of ON; start_i stays high during the flush.
    signed_i = 1'b0;
    op1_i    = 32'd100;
    op2_i    = 32'd7;
    start_i  = 1'b1;
    rdy_seen = 1'b0;
    for (k = 0; k < 10; k++) begin
      next_cycle();
      if (ready_o) rdy_seen = 1'b1;
    end
    annul_i = 1'b1;
    #1;
    chk("annul stall", {31'd0, stall_req_o}, 32'd0);
    next_cycle();
    if (ready_o) rdy_seen = 1'b1;
    annul_i = 1'b0;
    start_i = 1'b0;
    chk("annul no_rdy", {31'd0, rdy_seen}, 32'd0);
    chk("annul quot", quot_o, 32'd0);
    do_div("post_annul", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33);

    // Reset in the middle of ON with start_i held; fresh operation afterwards.
    signed_i = 1'b0;
    op1_i    = 32'd1000;
    op2_i    = 32'd9;
    start_i  = 1'b1;
    for (k = 0; k < 20; k++) next_cycle();
    rst_i = 1'b1;
    #1;
    chk("rst_mid stall", {31'd0, stall_req_o}, 32'd0);
    next_cycle();
    chk("rst_mid ready", {31'd0, ready_o}, 32'd0);
    chk("rst_mid quot", quot_o, 32'd0);
    chk("rst_mid rem", rem_o, 32'd0);
    rst_i = 1'b0;
    do_div("post_rst", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
